// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared types and constants for the core fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_STALL = 2'd2,
        FETCH_HALT  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

    // Sequential PC increment; wraps naturally at the top of the address space.
    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : core_fetch_queue
//  Description : Synchronous FIFO of fetch entries; flush beats push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign full      = (r_count == c_cnt_max);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !rst) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : core_fetch
//  Description : Instruction fetch unit with PC tracking, response queue and
//                redirect flush. CORE_FETCH_MISALIGN_CHECK_EN turns misaligned
//                redirect targets into a fault entry instead of a fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    input  logic        instr_ready
);

    localparam int c_cnt_w = $clog2(QUEUE_DEPTH + 1);
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(QUEUE_DEPTH);
    localparam logic [c_cnt_w:0] c_one   = (c_cnt_w + 1)'(1);

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        w_fetch_pc_next;
    logic [31:0]        r_req_addr;
    logic [31:0]        w_req_addr_next;
    logic               r_stale;
    logic               w_stale_next;
    logic               r_mis;
    logic               w_mis_next;
    logic [31:0]        w_redir_pc;
    logic               w_redir_mis;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_space;
    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w:0]   w_occ_next;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;

`ifdef CORE_FETCH_MISALIGN_CHECK_EN
    assign w_redir_pc  = redirect_pc;
    assign w_redir_mis = |redirect_pc[1:0];
`else
    assign w_redir_pc  = redirect_pc & ~32'h3;
    assign w_redir_mis = 1'b0;
`endif

    core_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .flush      (redirect),
        .full       (w_full),
        .empty      (w_empty),
        .count      (w_count),
        .head       (w_head)
    );

    assign mem_req     = (r_state == FETCH_REQ);
    assign mem_addr    = r_req_addr;
    assign instr_valid = ~w_empty;
    assign instr       = w_empty ? 32'h0 : w_head.instr;
    assign instr_pc    = w_empty ? 32'h0 : w_head.pc;
    assign instr_fault = w_empty ? 1'b0  : w_head.fault;
    assign w_pop       = ~w_empty & instr_ready;

    // Pushes: live responses in WAIT, or a pending misalignment fault in STALL.
    always_comb begin
        w_push       = 1'b0;
        w_push_entry = '0;
        if (r_state == FETCH_WAIT && mem_rvalid && !r_stale && !redirect) begin
            w_push             = 1'b1;
            w_push_entry.instr = mem_err ? 32'h0 : mem_rdata;
            w_push_entry.pc    = r_fetch_pc;
            w_push_entry.fault = mem_err;
        end else if (r_state == FETCH_STALL && r_mis && !redirect && !w_full) begin
            w_push             = 1'b1;
            w_push_entry.pc    = r_fetch_pc;
            w_push_entry.fault = 1'b1;
        end
    end

    // Queue occupancy as it will be after this cycle, used by the space rule.
    always_comb begin
        w_occ_next = {1'b0, w_count};
        if (redirect) begin
            w_occ_next = '0;
        end else begin
            if (w_push) begin
                w_occ_next = w_occ_next + c_one;
            end
            if (w_pop) begin
                w_occ_next = w_occ_next - c_one;
            end
        end
    end

    assign w_space = (w_occ_next < c_depth);

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_req_addr_next = r_req_addr;
        w_stale_next    = r_stale;
        w_mis_next      = r_mis;
        if (redirect) begin
            w_fetch_pc_next = w_redir_pc;
            w_mis_next      = w_redir_mis;
            case (r_state)
                // An ungranted request keeps its address on the bus; only its
                // response is marked for dropping.
                FETCH_REQ: begin
                    w_stale_next = 1'b1;
                    if (mem_gnt) begin
                        w_state_next = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (mem_rvalid) begin
                        w_stale_next    = 1'b0;
                        w_req_addr_next = w_redir_pc;
                        w_state_next    = w_redir_mis ? FETCH_STALL : FETCH_REQ;
                    end else begin
                        w_stale_next = 1'b1;
                    end
                end
                default: begin
                    w_stale_next    = 1'b0;
                    w_req_addr_next = w_redir_pc;
                    w_state_next    = w_redir_mis ? FETCH_STALL : FETCH_REQ;
                end
            endcase
        end else begin
            case (r_state)
                FETCH_REQ: begin
                    if (mem_gnt) begin
                        w_state_next = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (mem_rvalid) begin
                        if (r_stale) begin
                            w_stale_next    = 1'b0;
                            w_req_addr_next = r_fetch_pc;
                            w_state_next    = (!r_mis && w_space) ? FETCH_REQ : FETCH_STALL;
                        end else begin
                            w_fetch_pc_next = pc_step(r_fetch_pc);
                            w_req_addr_next = pc_step(r_fetch_pc);
                            if (mem_err) begin
                                w_state_next = FETCH_HALT;
                            end else begin
                                w_state_next = w_space ? FETCH_REQ : FETCH_STALL;
                            end
                        end
                    end
                end
                FETCH_STALL: begin
                    if (r_mis) begin
                        if (w_push) begin
                            w_mis_next   = 1'b0;
                            w_state_next = FETCH_HALT;
                        end
                    end else if (w_space) begin
                        w_req_addr_next = r_fetch_pc;
                        w_state_next    = FETCH_REQ;
                    end
                end
                default: begin
                    w_state_next = FETCH_HALT;
                end
            endcase
        end
    end

    // Reset parks in STALL so the first request appears one cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH_STALL;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_stale    <= 1'b0;
            r_mis      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_req_addr <= w_req_addr_next;
            r_stale    <= w_stale_next;
            r_mis      <= w_mis_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_fetch
//  Description : Directed self-checking bench for core_fetch with a
//                one-cycle-latency instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_fetch;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        instr_ready;

    int          n_cmp;
    int          n_bad;
    logic        gnt_en;
    logic        rdy_en;
    logic [31:0] err_addr;
    logic        rsp_pend;
    logic [31:0] rsp_addr;
    logic [31:0] iss_q[$];
    logic [64:0] pop_q[$];

    core_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_fault (instr_fault),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs after the edge, then log grants and pops.
    task automatic step(input logic redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        redirect    = redir;
        redirect_pc = rpc;
        mem_gnt     = gnt_en;
        instr_ready = rdy_en;
        mem_rvalid  = rsp_pend;
        mem_rdata   = rsp_pend ? (rsp_addr ^ 32'h0000_0013) : 32'h0;
        mem_err     = rsp_pend && (rsp_addr == err_addr);
        #1;
        if (rst) begin
            rsp_pend = 1'b0;
        end else begin
            rsp_pend = mem_req && mem_gnt;
            if (mem_req && mem_gnt) begin
                rsp_addr = mem_addr;
                iss_q.push_back(mem_addr);
            end
            if (instr_valid && instr_ready && !redirect) begin
                pop_q.push_back({instr, instr_pc, instr_fault});
            end
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        gnt_en   = 1'b0;
        rdy_en   = 1'b0;
        err_addr = 32'hFFFF_FFFF;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        rst = 1'b0;
        iss_q.delete();
        pop_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_cmp++; if ({instr, instr_pc, instr_fault} !== 65'h0) begin n_bad++; $display("FAIL reset_head: got %h/%h/%b want 0", instr, instr_pc, instr_fault); end
        step(1'b0, 32'h0);
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL first_req: got %b@%h want 1@00000000", mem_req, mem_addr); end
    endtask

    task automatic test_gnt_stall();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0);
            n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL gnt_stall_hold%0d: got %b@%h want 1@00000000", i, mem_req, mem_addr); end
        end
        gnt_en = 1'b1;
        step(1'b0, 32'h0);
        n_cmp++; if (iss_q.size() !== 1) begin n_bad++; $display("FAIL gnt_stall_grant: got %0d issues want 1", iss_q.size()); end
        step(1'b0, 32'h0);
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL latency_early: got valid %b want 0", instr_valid); end
        step(1'b0, 32'h0);
        n_cmp++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h13, 32'h0}) begin n_bad++; $display("FAIL latency_head: got %b %h@%h want 1 00000013@00000000", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        gnt_en = 1'b1;
        rdy_en = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
        n_cmp++; if (iss_q.size() !== 5) begin n_bad++; $display("FAIL b2b_issue_count: got %0d want 5", iss_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (iss_q[i] !== 32'(i * 4)) begin n_bad++; $display("FAIL b2b_addr%0d: got %h want %h", i, iss_q[i], 32'(i * 4)); end
        end
        n_cmp++; if (pop_q.size() !== 4) begin n_bad++; $display("FAIL b2b_pop_count: got %0d want 4", pop_q.size()); end
        n_cmp++; if (pop_q[0] !== {32'h13, 32'h0, 1'b0}) begin n_bad++; $display("FAIL b2b_entry0: got %h want %h", pop_q[0], {32'h13, 32'h0, 1'b0}); end
        n_cmp++; if (pop_q[1] !== {32'h17, 32'h4, 1'b0}) begin n_bad++; $display("FAIL b2b_entry1: got %h want %h", pop_q[1], {32'h17, 32'h4, 1'b0}); end
    endtask

    task automatic test_backpressure();
        do_reset();
        gnt_en = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0);
        n_cmp++; if (iss_q.size() !== 2) begin n_bad++; $display("FAIL bp_issue_count: got %0d want 2", iss_q.size()); end
        n_cmp++; if ({mem_req, instr_valid} !== 2'b01) begin n_bad++; $display("FAIL bp_idle: got req %b valid %b want 0 1", mem_req, instr_valid); end
        rdy_en = 1'b1;
        step(1'b0, 32'h0);
        rdy_en = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
        n_cmp++; if (iss_q.size() !== 3) begin n_bad++; $display("FAIL bp_one_more: got %0d issues want 3", iss_q.size()); end
        n_cmp++; if (iss_q[2] !== 32'h8) begin n_bad++; $display("FAIL bp_addr: got %h want 00000008", iss_q[2]); end
        n_cmp++; if (instr_pc !== 32'h4) begin n_bad++; $display("FAIL bp_head_pc: got %h want 00000004", instr_pc); end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        gnt_en = 1'b1;
        rdy_en = 1'b1;
        for (int i = 0; i < 9; i++) step(1'b0, 32'h0);
        n_cmp++; if (iss_q[4] !== 32'h10) begin n_bad++; $display("FAIL redir_pre_addr: got %h want 00000010", iss_q[4]); end
        step(1'b1, 32'h8000_0000);
        iss_q.delete();
        pop_q.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
        n_cmp++; if (iss_q[0] !== 32'h8000_0000) begin n_bad++; $display("FAIL redir_new_addr: got %h want 80000000", iss_q[0]); end
        n_cmp++; if (pop_q.size() !== 2) begin n_bad++; $display("FAIL redir_pop_count: got %0d want 2", pop_q.size()); end
        n_cmp++; if (pop_q[0] !== {32'h8000_0013, 32'h8000_0000, 1'b0}) begin n_bad++; $display("FAIL redir_entry0: got %h want %h", pop_q[0], {32'h8000_0013, 32'h8000_0000, 1'b0}); end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        gnt_en = 1'b1;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        gnt_en = 1'b0;
        step(1'b0, 32'h0);
        step(1'b1, 32'h200);
        iss_q.delete();
        step(1'b0, 32'h0);
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL pend_flush: got valid %b want 0", instr_valid); end
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h4}) begin n_bad++; $display("FAIL pend_bus_stable: got %b@%h want 1@00000004", mem_req, mem_addr); end
        gnt_en = 1'b1;
        rdy_en = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
        n_cmp++; if ({iss_q[0], iss_q[1]} !== {32'h4, 32'h200}) begin n_bad++; $display("FAIL pend_issue_order: got %h %h want 00000004 00000200", iss_q[0], iss_q[1]); end
        n_cmp++; if (pop_q[0] !== {32'h213, 32'h200, 1'b0}) begin n_bad++; $display("FAIL pend_entry0: got %h want %h", pop_q[0], {32'h213, 32'h200, 1'b0}); end
    endtask

    task automatic test_fault_halt();
        do_reset();
        gnt_en   = 1'b1;
        rdy_en   = 1'b1;
        err_addr = 32'h20;
        for (int i = 0; i < 24; i++) step(1'b0, 32'h0);
        n_cmp++; if (iss_q.size() !== 9) begin n_bad++; $display("FAIL halt_issue_count: got %0d want 9", iss_q.size()); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL halt_no_req: got %b want 0", mem_req); end
        n_cmp++; if (pop_q[7] !== {32'h0F, 32'h1C, 1'b0}) begin n_bad++; $display("FAIL halt_before_fault: got %h want %h", pop_q[7], {32'h0F, 32'h1C, 1'b0}); end
        n_cmp++; if (pop_q[8] !== {32'h0, 32'h20, 1'b1}) begin n_bad++; $display("FAIL halt_fault_entry: got %h want %h", pop_q[8], {32'h0, 32'h20, 1'b1}); end
        err_addr = 32'hFFFF_FFFF;
        step(1'b1, 32'h100);
        step(1'b0, 32'h0);
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL halt_resume: got %b@%h want 1@00000100", mem_req, mem_addr); end
    endtask

    task automatic test_misalign();
        do_reset();
        gnt_en   = 1'b1;
        rdy_en   = 1'b1;
        err_addr = 32'h0;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
        err_addr = 32'hFFFF_FFFF;
        iss_q.delete();
        pop_q.delete();
        step(1'b1, 32'h102);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0);
`ifdef CORE_FETCH_MISALIGN_CHECK_EN
        n_cmp++; if (iss_q.size() !== 0) begin n_bad++; $display("FAIL mis_no_req: got %0d issues want 0", iss_q.size()); end
        n_cmp++; if (pop_q[0] !== {32'h0, 32'h102, 1'b1}) begin n_bad++; $display("FAIL mis_fault_entry: got %h want %h", pop_q[0], {32'h0, 32'h102, 1'b1}); end
`else
        n_cmp++; if (iss_q[0] !== 32'h100) begin n_bad++; $display("FAIL mis_aligned_addr: got %h want 00000100", iss_q[0]); end
        n_cmp++; if (pop_q[0] !== {32'h113, 32'h100, 1'b0}) begin n_bad++; $display("FAIL mis_aligned_entry: got %h want %h", pop_q[0], {32'h113, 32'h100, 1'b0}); end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        gnt_en = 1'b1;
        rdy_en = 1'b1;
        step(1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 7; i++) step(1'b0, 32'h0);
        n_cmp++; if ({iss_q[1], iss_q[2]} !== {32'hFFFF_FFFC, 32'h0}) begin n_bad++; $display("FAIL wrap_addr: got %h %h want FFFFFFFC 00000000", iss_q[1], iss_q[2]); end
        n_cmp++; if (pop_q[0] !== {32'hFFFF_FFEF, 32'hFFFF_FFFC, 1'b0}) begin n_bad++; $display("FAIL wrap_entry0: got %h want %h", pop_q[0], {32'hFFFF_FFEF, 32'hFFFF_FFFC, 1'b0}); end
        n_cmp++; if (pop_q[1] !== {32'h13, 32'h0, 1'b0}) begin n_bad++; $display("FAIL wrap_entry1: got %h want %h", pop_q[1], {32'h13, 32'h0, 1'b0}); end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        mem_err     = 1'b0;
        instr_ready = 1'b0;
        gnt_en      = 1'b0;
        rdy_en      = 1'b0;
        err_addr    = 32'hFFFF_FFFF;
        rsp_pend    = 1'b0;
        rsp_addr    = 32'h0;
        test_reset();
        test_gnt_stall();
        test_back_to_back();
        test_backpressure();
        test_redirect_rvalid();
        test_redirect_pending();
        test_fault_halt();
        test_misalign();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
